// File: rtl/axilite_buffer_if.sv
// AXI4-Lite bundle shared by both sides of the buffering stage.
interface axilite_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STROBE_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [STROBE_WIDTH-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axilite_buffer.sv
// AXI4-Lite buffering stage: per-channel pass-through or N-entry FIFO,
// plus write/read outstanding-transaction limiters on AW/AR.
module axilite_buffer_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  // Readiness is a function of stored occupancy only; rst forces both sides idle.
  assign in_ready_o  = !rst && (count_q != CW'(DEPTH));
  assign out_valid_o = !rst && (count_q != '0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= in_data_i;
    end
  end
endmodule

module axilite_buffer #(
  parameter int AW_DEPTH           = 2,
  parameter int W_DEPTH            = 2,
  parameter int B_DEPTH            = 2,
  parameter int AR_DEPTH           = 2,
  parameter int R_DEPTH            = 2,
  parameter int MAX_WR_OUTSTANDING = 4,
  parameter int MAX_RD_OUTSTANDING = 4,
  localparam int WR_CW = (MAX_WR_OUTSTANDING > 0) ? $clog2(MAX_WR_OUTSTANDING + 1) : 1,
  localparam int RD_CW = (MAX_RD_OUTSTANDING > 0) ? $clog2(MAX_RD_OUTSTANDING + 1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  axilite_if.slave         s_axilite,
  axilite_if.master        m_axilite,
  output logic [WR_CW-1:0] wr_outstanding,
  output logic [RD_CW-1:0] rd_outstanding
);
  localparam int ADDR_W = $bits(s_axilite.awaddr);
  localparam int DATA_W = $bits(s_axilite.wdata);
  localparam int STRB_W = $bits(s_axilite.wstrb);
  localparam int AXP    = ADDR_W + 3;
  localparam int WP     = DATA_W + STRB_W;
  localparam int RP     = DATA_W + 2;

  logic [AXP-1:0]   aw_in, aw_out, ar_in, ar_out;
  logic [WP-1:0]    w_in, w_out;
  logic [RP-1:0]    r_in, r_out;
  logic             aw_hvalid, aw_hready, aw_allow;
  logic             ar_hvalid, ar_hready, ar_allow;
  logic [WR_CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [RD_CW-1:0] rd_cnt_q, rd_cnt_d;
  logic             wr_inc, wr_dec, rd_inc, rd_dec;

  assign aw_in = {s_axilite.awprot, s_axilite.awaddr};
  assign ar_in = {s_axilite.arprot, s_axilite.araddr};
  assign w_in  = {s_axilite.wstrb, s_axilite.wdata};
  assign r_in  = {m_axilite.rresp, m_axilite.rdata};
  assign {m_axilite.awprot, m_axilite.awaddr} = aw_out;
  assign {m_axilite.arprot, m_axilite.araddr} = ar_out;
  assign {m_axilite.wstrb, m_axilite.wdata}   = w_out;
  assign {s_axilite.rresp, s_axilite.rdata}   = r_out;

  // Limiter gates the head of AW/AR identically on valid and on pop.
  assign m_axilite.awvalid = aw_hvalid & aw_allow;
  assign aw_hready         = m_axilite.awready & aw_allow;
  assign m_axilite.arvalid = ar_hvalid & ar_allow;
  assign ar_hready         = m_axilite.arready & ar_allow;

  if (AW_DEPTH == 0) begin : g_aw_pass
    assign aw_out = aw_in;
    assign aw_hvalid = s_axilite.awvalid;
    assign s_axilite.awready = aw_hready;
  end else begin : g_aw_fifo
    axilite_buffer_fifo #(.DEPTH(AW_DEPTH), .WIDTH(AXP)) u_fifo (
      .clk(clk), .rst(rst), .in_data_i(aw_in), .in_valid_i(s_axilite.awvalid),
      .in_ready_o(s_axilite.awready), .out_data_o(aw_out), .out_valid_o(aw_hvalid),
      .out_ready_i(aw_hready));
  end

  if (W_DEPTH == 0) begin : g_w_pass
    assign w_out = w_in;
    assign m_axilite.wvalid = s_axilite.wvalid;
    assign s_axilite.wready = m_axilite.wready;
  end else begin : g_w_fifo
    axilite_buffer_fifo #(.DEPTH(W_DEPTH), .WIDTH(WP)) u_fifo (
      .clk(clk), .rst(rst), .in_data_i(w_in), .in_valid_i(s_axilite.wvalid),
      .in_ready_o(s_axilite.wready), .out_data_o(w_out), .out_valid_o(m_axilite.wvalid),
      .out_ready_i(m_axilite.wready));
  end

  if (B_DEPTH == 0) begin : g_b_pass
    assign s_axilite.bresp  = m_axilite.bresp;
    assign s_axilite.bvalid = m_axilite.bvalid;
    assign m_axilite.bready = s_axilite.bready;
  end else begin : g_b_fifo
    axilite_buffer_fifo #(.DEPTH(B_DEPTH), .WIDTH(2)) u_fifo (
      .clk(clk), .rst(rst), .in_data_i(m_axilite.bresp), .in_valid_i(m_axilite.bvalid),
      .in_ready_o(m_axilite.bready), .out_data_o(s_axilite.bresp),
      .out_valid_o(s_axilite.bvalid), .out_ready_i(s_axilite.bready));
  end

  if (AR_DEPTH == 0) begin : g_ar_pass
    assign ar_out = ar_in;
    assign ar_hvalid = s_axilite.arvalid;
    assign s_axilite.arready = ar_hready;
  end else begin : g_ar_fifo
    axilite_buffer_fifo #(.DEPTH(AR_DEPTH), .WIDTH(AXP)) u_fifo (
      .clk(clk), .rst(rst), .in_data_i(ar_in), .in_valid_i(s_axilite.arvalid),
      .in_ready_o(s_axilite.arready), .out_data_o(ar_out), .out_valid_o(ar_hvalid),
      .out_ready_i(ar_hready));
  end

  if (R_DEPTH == 0) begin : g_r_pass
    assign r_out = r_in;
    assign s_axilite.rvalid = m_axilite.rvalid;
    assign m_axilite.rready = s_axilite.rready;
  end else begin : g_r_fifo
    axilite_buffer_fifo #(.DEPTH(R_DEPTH), .WIDTH(RP)) u_fifo (
      .clk(clk), .rst(rst), .in_data_i(r_in), .in_valid_i(m_axilite.rvalid),
      .in_ready_o(m_axilite.rready), .out_data_o(r_out), .out_valid_o(s_axilite.rvalid),
      .out_ready_i(s_axilite.rready));
  end

  if (MAX_WR_OUTSTANDING == 0) begin : g_wr_unlim
    assign aw_allow = 1'b1;
  end else begin : g_wr_lim
    assign aw_allow = (wr_cnt_q < WR_CW'(MAX_WR_OUTSTANDING));
  end

  if (MAX_RD_OUTSTANDING == 0) begin : g_rd_unlim
    assign ar_allow = 1'b1;
  end else begin : g_rd_lim
    assign ar_allow = (rd_cnt_q < RD_CW'(MAX_RD_OUTSTANDING));
  end

  assign wr_inc = m_axilite.awvalid & m_axilite.awready;
  assign wr_dec = s_axilite.bvalid & s_axilite.bready;
  assign rd_inc = m_axilite.arvalid & m_axilite.arready;
  assign rd_dec = s_axilite.rvalid & s_axilite.rready;

  // Limited counters hold at zero on underflow; unlimited ones free-run and wrap.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (wr_inc && !wr_dec) wr_cnt_d = wr_cnt_q + 1'b1;
    else if (wr_dec && !wr_inc && (wr_cnt_q != '0 || MAX_WR_OUTSTANDING == 0))
      wr_cnt_d = wr_cnt_q - 1'b1;
    if (rd_inc && !rd_dec) rd_cnt_d = rd_cnt_q + 1'b1;
    else if (rd_dec && !rd_inc && (rd_cnt_q != '0 || MAX_RD_OUTSTANDING == 0))
      rd_cnt_d = rd_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && MAX_WR_OUTSTANDING > 0) assert (!(wr_dec && !wr_inc && wr_cnt_q == '0));
    if (!rst && MAX_RD_OUTSTANDING > 0) assert (!(rd_dec && !rd_inc && rd_cnt_q == '0));
  end

  assign wr_outstanding = rst ? '0 : wr_cnt_q;
  assign rd_outstanding = rst ? '0 : rd_cnt_q;
endmodule

// File: tb/tb_axilite_buffer.sv
// Directed checks of axilite_buffer: a buffered instance (AR depth 4, write cap 2,
// unlimited reads) and an all-pass-through instance.
module tb_axilite_buffer;
  logic clk, rst;
  logic [1:0] a_wr;
  logic [0:0] a_rd;
  logic [2:0] p_wr, p_rd;
  int total = 0;
  int bad   = 0;

  axilite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STROBE_WIDTH(4)) a_s ();
  axilite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STROBE_WIDTH(4)) a_m ();
  axilite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STROBE_WIDTH(4)) p_s ();
  axilite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STROBE_WIDTH(4)) p_m ();

  axilite_buffer #(
    .AW_DEPTH(2), .W_DEPTH(2), .B_DEPTH(2), .AR_DEPTH(4), .R_DEPTH(2),
    .MAX_WR_OUTSTANDING(2), .MAX_RD_OUTSTANDING(0)
  ) u_buf (
    .clk(clk), .rst(rst), .s_axilite(a_s), .m_axilite(a_m),
    .wr_outstanding(a_wr), .rd_outstanding(a_rd)
  );

  axilite_buffer #(
    .AW_DEPTH(0), .W_DEPTH(0), .B_DEPTH(0), .AR_DEPTH(0), .R_DEPTH(0),
    .MAX_WR_OUTSTANDING(4), .MAX_RD_OUTSTANDING(4)
  ) u_pass (
    .clk(clk), .rst(rst), .s_axilite(p_s), .m_axilite(p_m),
    .wr_outstanding(p_wr), .rd_outstanding(p_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] dsq[$];
    logic [31:0] addr;
    logic hs_up, hs_dn, hs_r, hs_w;
    int sent, rcv, first, last, idx, widx;

    rst = 1'b1;
    a_s.awvalid = 0; a_s.awaddr = '0; a_s.awprot = '0;
    a_s.wvalid = 0; a_s.wdata = '0; a_s.wstrb = '0; a_s.bready = 1;
    a_s.arvalid = 0; a_s.araddr = '0; a_s.arprot = '0; a_s.rready = 1;
    a_m.awready = 1; a_m.wready = 1; a_m.bvalid = 0; a_m.bresp = '0;
    a_m.arready = 1; a_m.rvalid = 0; a_m.rdata = '0; a_m.rresp = '0;
    p_s.awvalid = 0; p_s.awaddr = '0; p_s.awprot = '0;
    p_s.wvalid = 0; p_s.wdata = '0; p_s.wstrb = '0; p_s.bready = 1;
    p_s.arvalid = 0; p_s.araddr = '0; p_s.arprot = '0; p_s.rready = 1;
    p_m.awready = 1; p_m.wready = 1; p_m.bvalid = 0; p_m.bresp = '0;
    p_m.arready = 1; p_m.rvalid = 0; p_m.rdata = '0; p_m.rresp = '0;

    // Reset state
    step(); step();
    chk("rst_awready", a_s.awready, 0);
    chk("rst_awvalid", a_m.awvalid, 0);
    chk("rst_bvalid", a_s.bvalid, 0);
    chk("rst_wr_cnt", a_wr, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_awready", a_s.awready, 1);
    chk("post_rst_arready", a_s.arready, 1);

    // Pass-through instance: same-cycle visibility both directions
    p_s.awvalid = 1; p_s.awaddr = 32'h44; p_s.awprot = 3'b010; p_m.awready = 0;
    #1;
    chk("pt_awvalid", p_m.awvalid, 1);
    chk("pt_awaddr", p_m.awaddr, 32'h44);
    chk("pt_awprot", p_m.awprot, 3'b010);
    chk("pt_awready_lo", p_s.awready, 0);
    p_m.awready = 1;
    #1;
    chk("pt_awready_hi", p_s.awready, 1);
    step();
    p_s.awvalid = 0;
    #1;
    chk("pt_wr_cnt1", p_wr, 1);
    p_s.wvalid = 1; p_s.wdata = 32'h12345678; p_s.wstrb = 4'h3; p_m.wready = 1;
    #1;
    chk("pt_wvalid", p_m.wvalid, 1);
    chk("pt_wdata", p_m.wdata, 32'h12345678);
    chk("pt_wstrb", p_m.wstrb, 4'h3);
    chk("pt_wready", p_s.wready, 1);
    step();
    p_s.wvalid = 0;
    p_m.bvalid = 1; p_m.bresp = 2'b10; p_s.bready = 0;
    #1;
    chk("pt_bvalid", p_s.bvalid, 1);
    chk("pt_bresp", p_s.bresp, 2'b10);
    chk("pt_bready_lo", p_m.bready, 0);
    p_s.bready = 1;
    #1;
    chk("pt_bready_hi", p_m.bready, 1);
    step();
    p_m.bvalid = 0;
    #1;
    chk("pt_wr_cnt0", p_wr, 0);
    p_s.arvalid = 1; p_s.araddr = 32'h88;
    #1;
    chk("pt_arvalid", p_m.arvalid, 1);
    chk("pt_araddr", p_m.araddr, 32'h88);
    chk("pt_arready", p_s.arready, 1);
    step();
    p_s.arvalid = 0;
    p_m.rvalid = 1; p_m.rdata = 32'hCAFEF00D; p_m.rresp = 2'b01;
    #1;
    chk("pt_rvalid", p_s.rvalid, 1);
    chk("pt_rdata", p_s.rdata, 32'hCAFEF00D);
    chk("pt_rresp", p_s.rresp, 2'b01);
    chk("pt_rready", p_m.rready, 1);
    step();
    p_m.rvalid = 0;
    #1;
    chk("pt_rd_cnt0", p_rd, 0);

    // Single write through the buffered instance
    a_s.awvalid = 1; a_s.awaddr = 32'h10;
    a_s.wvalid = 1; a_s.wdata = 32'hDEADBEEF; a_s.wstrb = 4'hF;
    #1;
    chk("wr_no_bypass", a_m.awvalid, 0);
    step();
    a_s.awvalid = 0; a_s.wvalid = 0;
    #1;
    chk("wr_awvalid", a_m.awvalid, 1);
    chk("wr_awaddr", a_m.awaddr, 32'h10);
    chk("wr_wvalid", a_m.wvalid, 1);
    chk("wr_wdata", a_m.wdata, 32'hDEADBEEF);
    chk("wr_wstrb", a_m.wstrb, 4'hF);
    chk("wr_cnt_pre", a_wr, 0);
    step();
    chk("wr_cnt_1", a_wr, 1);
    chk("wr_aw_done", a_m.awvalid, 0);
    a_m.bvalid = 1; a_m.bresp = 2'b00;
    #1;
    chk("wr_bready", a_m.bready, 1);
    step();
    a_m.bvalid = 0;
    #1;
    chk("wr_s_bvalid", a_s.bvalid, 1);
    chk("wr_s_bresp", a_s.bresp, 2'b00);
    step();
    chk("wr_cnt_0", a_wr, 0);
    chk("wr_b_done", a_s.bvalid, 0);

    // 16 back-to-back reads, downstream slave answers addr ^ A5A50000
    sent = 0; rcv = 0; first = -1; last = -1;
    for (int c = 0; c < 40; c++) begin
      a_s.arvalid = (sent < 16);
      a_s.araddr = 32'h100 + 32'(sent * 4);
      a_m.rvalid = (q.size() > 0);
      a_m.rdata = (q.size() > 0) ? q[0] : '0;
      a_m.rresp = 2'b00;
      #1;
      hs_up = a_s.arvalid && a_s.arready;
      hs_dn = a_m.arvalid && a_m.arready;
      hs_r = a_m.rvalid && a_m.rready;
      addr = a_m.araddr;
      if (a_s.rvalid && a_s.rready) begin
        chk("rd_data", a_s.rdata, 32'hA5A50000 ^ (32'h100 + 32'(rcv * 4)));
        rcv++;
      end
      step();
      if (hs_up) sent++;
      if (hs_r) void'(q.pop_front());
      if (hs_dn) begin
        q.push_back(addr ^ 32'hA5A50000);
        if (first < 0) first = c;
        last = c;
      end
    end
    a_s.arvalid = 0; a_m.rvalid = 0;
    chk("rd_beats", rcv, 16);
    chk("rd_ar_span", last - first, 15);

    // Write limiter with MAX=2, no B returned
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      a_s.awvalid = (idx < 4);
      a_s.awaddr = 32'h200 + 32'(idx * 16);
      #1;
      hs_up = a_s.awvalid && a_s.awready;
      hs_dn = a_m.awvalid && a_m.awready;
      addr = a_m.awaddr;
      step();
      if (hs_up) idx++;
      if (hs_dn) dsq.push_back(addr);
    end
    a_s.awvalid = 0;
    chk("lim_accepted", idx, 4);
    chk("lim_issued", dsq.size(), 2);
    chk("lim_aw0", dsq[0], 32'h200);
    chk("lim_aw1", dsq[1], 32'h210);
    chk("lim_awvalid_gated", a_m.awvalid, 0);
    chk("lim_wr_cnt", a_wr, 2);
    chk("lim_awready_full", a_s.awready, 0);
    a_m.bvalid = 1;
    step();
    a_m.bvalid = 0;
    #1;
    chk("lim_still_gated", a_m.awvalid, 0);
    step();
    chk("lim_third_valid", a_m.awvalid, 1);
    chk("lim_third_addr", a_m.awaddr, 32'h220);
    step();
    chk("lim_regated", a_m.awvalid, 0);
    chk("lim_wr_cnt_2b", a_wr, 2);
    idx = 0; addr = '0;
    for (int c = 0; c < 10; c++) begin
      a_m.bvalid = (c < 3);
      #1;
      hs_dn = a_m.awvalid && a_m.awready;
      if (hs_dn) addr = a_m.awaddr;
      step();
      if (hs_dn) idx++;
    end
    a_m.bvalid = 0;
    chk("lim_drain_count", idx, 1);
    chk("lim_fourth_addr", addr, 32'h230);
    chk("lim_wr_cnt_end", a_wr, 0);

    // AR FIFO depth 4 with downstream stalled
    a_m.arready = 0; idx = 0;
    for (int c = 0; c < 12; c++) begin
      a_s.arvalid = (idx < 6);
      a_s.araddr = 32'h300 + 32'(idx * 4);
      #1;
      hs_up = a_s.arvalid && a_s.arready;
      step();
      if (hs_up) idx++;
    end
    chk("ar_accepted", idx, 4);
    chk("ar_ready_full", a_s.arready, 0);
    chk("ar_head_valid", a_m.arvalid, 1);
    chk("ar_head_addr", a_m.araddr, 32'h300);
    a_m.arready = 1;
    dsq.delete();
    for (int c = 0; c < 16; c++) begin
      a_s.arvalid = (idx < 6);
      a_s.araddr = 32'h300 + 32'(idx * 4);
      #1;
      hs_up = a_s.arvalid && a_s.arready;
      hs_dn = a_m.arvalid && a_m.arready;
      addr = a_m.araddr;
      step();
      if (hs_up) idx++;
      if (hs_dn) dsq.push_back(addr);
    end
    a_s.arvalid = 0;
    chk("ar_drained", dsq.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < dsq.size()) chk("ar_order", dsq[k], 32'h300 + 32'(k * 4));

    // Reset with buffered beats and wr_cnt=2
    a_m.wready = 0; idx = 0; widx = 0;
    for (int c = 0; c < 8; c++) begin
      a_s.awvalid = (idx < 3);
      a_s.awaddr = 32'h400 + 32'(idx * 4);
      a_s.wvalid = (widx < 2);
      a_s.wdata = 32'h5000 + 32'(widx);
      a_s.wstrb = 4'hF;
      #1;
      hs_up = a_s.awvalid && a_s.awready;
      hs_w = a_s.wvalid && a_s.wready;
      step();
      if (hs_up) idx++;
      if (hs_w) widx++;
    end
    a_s.awvalid = 0; a_s.wvalid = 0;
    chk("pre_rst_aw", idx, 3);
    chk("pre_rst_w", widx, 2);
    chk("pre_rst_wr_cnt", a_wr, 2);
    chk("pre_rst_wvalid", a_m.wvalid, 1);
    chk("pre_rst_wready", a_s.wready, 0);
    rst = 1'b1;
    #1;
    chk("in_rst_wvalid", a_m.wvalid, 0);
    chk("in_rst_awready", a_s.awready, 0);
    chk("in_rst_wready", a_s.wready, 0);
    chk("in_rst_wr_cnt", a_wr, 0);
    step();
    rst = 1'b0;
    #1;
    chk("after_rst_valids", {a_m.awvalid, a_m.wvalid, a_m.arvalid, a_s.bvalid, a_s.rvalid}, 0);
    chk("after_rst_cnts", {a_wr, a_rd}, 0);
    chk("after_rst_readys", {a_s.awready, a_s.wready, a_s.arready, a_m.bready, a_m.rready}, 5'h1F);
    a_m.wready = 1; a_m.awready = 1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("no_stale_beat", {a_m.awvalid, a_m.wvalid}, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
